hyperram_phy_sequencer: RTL and testbench

HYPERRAM_PHY_SEQUENCER -- requirements
Module: hyperram_phy_sequencer

---
 rtl/hyperram_phy_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_hyperram_phy_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_phy_sequencer.sv
// HyperRAM PHY transaction sequencer: CA phase, initial latency, write/read data phases, CK park and CS recovery.
// Define HYPERRAM_BYTE_MASK_EN to add the WrMask port that drives RWDS as the write byte mask.
module hyperram_phy_sequencer #(
  parameter int LatencyCycles = 6,
  parameter int RecoveryTicks = 4,
  parameter int TimeoutTicks  = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [47:0] CmdCA,
  input  logic [7:0]  CmdLength,
  input  logic [7:0]  WrData,
`ifdef HYPERRAM_BYTE_MASK_EN
  input  logic        WrMask,
`endif
  output logic        WrTake,
  output logic [7:0]  RdData,
  output logic        RdValid,
  output logic        Done,
  output logic        Error,
  output logic        CS,
  output logic        CK,
  output logic [7:0]  Dout,
  output logic        DoutEn,
  input  logic [7:0]  Din,
  input  logic        RWDSin,
  output logic        RWDSout,
  output logic        RWDSEn
);

  localparam int LatMax  = 4 * LatencyCycles;
  localparam int CntMax0 = (LatMax > TimeoutTicks) ? LatMax : TimeoutTicks;
  localparam int CntMax  = (CntMax0 > RecoveryTicks) ? CntMax0 : RecoveryTicks;
  localparam int CntW    = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cntType;
  typedef enum logic [2:0] {IDLE, CA, LATENCY, WRITE, READ, PAD, RECOVER} stateType;

  stateType    state, stateNext;
  cntType      cnt, cntNext;
  logic [8:0]  byteCnt, byteNext;
  logic [47:0] caShift, caNext;
  logic [7:0]  len, lenNext;
  logic        isRd, rdNext, isReg, regNext;
  logic        dbl, dblNext, errFlag, errNext;
  logic        ck, ckNext, rwdsPrev, doneReg;
  logic        rwdsEdge, leaveData;
  cntType      latLast;
  logic [8:0]  wrLast;

  assign rwdsEdge = (RWDSin != rwdsPrev);
  assign latLast  = dbl ? cntType'(4 * LatencyCycles - 1) : cntType'(2 * LatencyCycles - 1);
  assign wrLast   = (!isRd && isReg) ? 9'd1 : {1'b0, len};
  assign Done     = doneReg;
  assign Error    = doneReg & errFlag;

  // Reset lands in RECOVER so the device always sees a full CS-high interval.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= RECOVER;
      cnt      <= cntType'(RecoveryTicks);
      byteCnt  <= '0;
      caShift  <= '0;
      len      <= '0;
      isRd     <= 1'b0;
      isReg    <= 1'b0;
      dbl      <= 1'b0;
      errFlag  <= 1'b0;
      ck       <= 1'b0;
      rwdsPrev <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      byteCnt  <= byteNext;
      caShift  <= caNext;
      len      <= lenNext;
      isRd     <= rdNext;
      isReg    <= regNext;
      dbl      <= dblNext;
      errFlag  <= errNext;
      ck       <= ckNext;
      rwdsPrev <= RWDSin;
      doneReg  <= (stateNext == RECOVER) && (state != RECOVER);
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    byteNext  = byteCnt;
    caNext    = caShift;
    lenNext   = len;
    rdNext    = isRd;
    regNext   = isReg;
    dblNext   = dbl;
    errNext   = errFlag;
    ckNext    = 1'b0;
    leaveData = 1'b0;
    CmdReady  = 1'b0;
    CS        = 1'b1;
    CK        = 1'b0;
    Dout      = 8'h00;
    DoutEn    = 1'b0;
    WrTake    = 1'b0;
    RdValid   = 1'b0;
    RdData    = Din;
    RWDSout   = 1'b0;
    RWDSEn    = 1'b0;
    case (state)
      IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) begin
          caNext    = CmdCA;
          lenNext   = CmdLength;
          rdNext    = CmdCA[47];
          regNext   = CmdCA[46];
          dblNext   = 1'b0;
          errNext   = 1'b0;
          cntNext   = '0;
          byteNext  = '0;
          ckNext    = 1'b1;
          stateNext = CA;
        end
      end
      CA: begin
        CS     = 1'b0;
        CK     = ck;
        ckNext = ~ck;
        Dout   = caShift[47:40];
        DoutEn = 1'b1;
        caNext = {caShift[39:0], 8'h00};
        cntNext = cnt + 1'b1;
        if (cnt == cntType'(2)) dblNext = RWDSin;
        if (cnt == cntType'(5)) begin
          cntNext   = '0;
          stateNext = (!isRd && isReg) ? WRITE : LATENCY;
        end
      end
      LATENCY: begin
        CS      = 1'b0;
        CK      = ck;
        ckNext  = ~ck;
        cntNext = cnt + 1'b1;
        if (cnt == latLast) begin
          cntNext   = '0;
          stateNext = isRd ? READ : WRITE;
        end
      end
      WRITE: begin
        CS       = 1'b0;
        CK       = ck;
        ckNext   = ~ck;
        WrTake   = 1'b1;
        Dout     = WrData;
        DoutEn   = 1'b1;
        RWDSEn   = 1'b1;
`ifdef HYPERRAM_BYTE_MASK_EN
        RWDSout  = WrMask;
`endif
        byteNext = byteCnt + 9'd1;
        if (byteCnt == wrLast) leaveData = 1'b1;
      end
      READ: begin
        CS     = 1'b0;
        CK     = ck;
        ckNext = ~ck;
        // The timeout counter restarts on every RWDS edge, so it measures edge-to-edge gaps.
        if (rwdsEdge) begin
          RdValid  = 1'b1;
          byteNext = byteCnt + 9'd1;
          cntNext  = '0;
          if (byteCnt == {1'b0, len}) leaveData = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
          if (cnt == cntType'(TimeoutTicks - 1)) begin
            leaveData = 1'b1;
            errNext   = 1'b1;
          end
        end
      end
      PAD: begin
        CS        = 1'b0;
        cntNext   = cntType'(RecoveryTicks);
        stateNext = RECOVER;
      end
      RECOVER: begin
        if (cnt <= cntType'(1)) stateNext = IDLE;
        else cntNext = cnt - 1'b1;
      end
      default: stateNext = RECOVER;
    endcase
    // A data phase that ends with CK high needs one PAD tick to park CK low before CS rises.
    if (leaveData) begin
      ckNext    = 1'b0;
      cntNext   = cntType'(RecoveryTicks);
      stateNext = ck ? PAD : RECOVER;
    end
  end

endmodule

// File: tb/tb_hyperram_phy_sequencer.sv
// Directed self-checking bench for hyperram_phy_sequencer: reads, doubled latency, writes, register write, timeout, reset.
module tb_hyperram_phy_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [47:0] CmdCA;
  logic [7:0]  CmdLength;
  logic [7:0]  WrData;
  logic        WrMask;
  logic        WrTake;
  logic [7:0]  RdData;
  logic        RdValid;
  logic        Done;
  logic        Error;
  logic        CS;
  logic        CK;
  logic [7:0]  Dout;
  logic        DoutEn;
  logic [7:0]  Din;
  logic        RWDSin;
  logic        RWDSout;
  logic        RWDSEn;

  int testsRun = 0;
  int testsFailed = 0;

  int doneTick, doneCount, readyTick, firstCap, capCount, wrCount, firstWr, ckEdges, wrSideBad;
  logic errAtDone, csAtDone, ckAtDone, csBeforeDone, ckBeforeDone;
  logic [7:0] caBytes [6];
  logic [7:0] capFirst, capLast;
  logic [7:0] wrSeq [8];
  logic [7:0] wrBytes [8];

  hyperram_phy_sequencer dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdCA(CmdCA), .CmdLength(CmdLength), .WrData(WrData),
`ifdef HYPERRAM_BYTE_MASK_EN
    .WrMask(WrMask),
`endif
    .WrTake(WrTake), .RdData(RdData), .RdValid(RdValid), .Done(Done), .Error(Error),
    .CS(CS), .CK(CK), .Dout(Dout), .DoutEn(DoutEn), .Din(Din),
    .RWDSin(RWDSin), .RWDSout(RWDSout), .RWDSEn(RWDSEn)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a command and return in the first tick after acceptance.
  task automatic startCmd(input logic [47:0] ca, input logic [7:0] len);
    int waited = 0;
    @(negedge Clk);
    CmdValid = 1'b1;
    CmdCA = ca;
    CmdLength = len;
    #1;
    while (!CmdReady && waited < 20) begin
      @(negedge Clk);
      #1;
      waited++;
    end
    checkOutput("cmd_ready_wait", {63'd0, CmdReady}, 64'd1);
    @(negedge Clk);
    CmdValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [47:0] ca, input logic [7:0] len, input bit dblHigh,
                               input int togStart, input int maxTicks);
    int wrIdx = 0;
    logic ckPrev = 1'b0;
    doneTick = -1; doneCount = 0; readyTick = -1; firstCap = -1; capCount = 0;
    wrCount = 0; firstWr = -1; ckEdges = 0; wrSideBad = 0;
    errAtDone = 1'b0; csAtDone = 1'b0; ckAtDone = 1'b1; csBeforeDone = 1'b1; ckBeforeDone = 1'b1;
    capFirst = 8'h00; capLast = 8'h00;
    foreach (caBytes[i]) caBytes[i] = 8'h00;
    foreach (wrBytes[i]) wrBytes[i] = 8'h00;
    startCmd(ca, len);
    for (int t = 0; t < maxTicks; t++) begin
      if (dblHigh && t == 2) RWDSin = 1'b1;
      else if (togStart >= 0 && t >= togStart) RWDSin = ((t - togStart) % 2 == 0);
      else RWDSin = 1'b0;
      Din = 8'hC0 + 8'(t);
      WrData = wrSeq[wrIdx];
      #1;
      if (t < 6 && DoutEn) caBytes[t] = Dout;
      if (RdValid) begin
        if (firstCap < 0) begin firstCap = t; capFirst = RdData; end
        capLast = RdData;
        capCount++;
      end
      if (WrTake) begin
        if (firstWr < 0) firstWr = t;
        wrBytes[wrCount] = Dout;
        if (RWDSEn !== 1'b1 || RWDSout !== 1'b0) wrSideBad++;
        wrCount++;
        if (wrIdx < 7) wrIdx++;
      end
      if (doneTick < 0) begin
        if (CK !== ckPrev) ckEdges++;
        ckPrev = CK;
      end
      if (Done) begin
        doneCount++;
        if (doneTick < 0) begin
          doneTick = t; errAtDone = Error; csAtDone = CS; ckAtDone = CK;
        end
      end
      if (doneTick < 0) begin csBeforeDone = CS; ckBeforeDone = CK; end
      if (CmdReady && readyTick < 0 && doneTick >= 0) readyTick = t;
      @(negedge Clk);
    end
  endtask

  initial begin
    int k;
    Reset = 1'b1; CmdValid = 1'b0; CmdCA = '0; CmdLength = '0; WrData = '0; WrMask = 1'b0;
    Din = '0; RWDSin = 1'b0;
    wrSeq[0] = 8'h11; wrSeq[1] = 8'h22; wrSeq[2] = 8'h33; wrSeq[3] = 8'h44;
    wrSeq[4] = 8'h55; wrSeq[5] = 8'h66; wrSeq[6] = 8'h77; wrSeq[7] = 8'h88;
    #1;
    checkOutput("reset_cs", {63'd0, CS}, 64'd1);
    checkOutput("reset_ck", {63'd0, CK}, 64'd0);
    checkOutput("reset_ready", {63'd0, CmdReady}, 64'd0);
    checkOutput("reset_done", {62'd0, Done, Error}, 64'd0);
    #20;
    Reset = 1'b0;

    // Plain read, 4 bytes, RWDS toggling from the first data tick.
    applyStimulus(48'hA00000000010, 8'd3, 1'b0, 18, 40);
    checkOutput("rd_ca0", {56'd0, caBytes[0]}, 64'hA0);
    checkOutput("rd_ca1_4", {caBytes[1], caBytes[2], caBytes[3], caBytes[4]}, 64'h0);
    checkOutput("rd_ca5", {56'd0, caBytes[5]}, 64'h10);
    checkOutput("rd_first_cap", 64'(firstCap), 64'd18);
    checkOutput("rd_cap_count", 64'(capCount), 64'd4);
    checkOutput("rd_cap_data", {48'd0, capFirst, capLast}, 64'hD2D5);
    checkOutput("rd_done_tick", 64'(doneTick), 64'd22);
    checkOutput("rd_done_state", {61'd0, csAtDone, ckAtDone, errAtDone}, 64'b100);
    checkOutput("rd_done_once", 64'(doneCount), 64'd1);

    // Same read with doubled latency requested on the third CA tick.
    applyStimulus(48'hA00000000010, 8'd3, 1'b1, 30, 50);
    checkOutput("dbl_first_cap", 64'(firstCap), 64'd30);
    checkOutput("dbl_cap_count", 64'(capCount), 64'd4);
    checkOutput("dbl_done_tick", 64'(doneTick), 64'd34);

    // Memory write, 3 bytes, ends with CK high so a PAD tick is needed.
    applyStimulus(48'h200000000000, 8'd2, 1'b0, -1, 40);
    checkOutput("wr_take_count", 64'(wrCount), 64'd3);
    checkOutput("wr_first_take", 64'(firstWr), 64'd18);
    checkOutput("wr_bytes", {40'd0, wrBytes[0], wrBytes[1], wrBytes[2]}, 64'h112233);
    checkOutput("wr_rwds_side", 64'(wrSideBad), 64'd0);
    checkOutput("wr_pad_tick", {62'd0, csBeforeDone, ckBeforeDone}, 64'b00);
    checkOutput("wr_done_tick", 64'(doneTick), 64'd22);
    checkOutput("wr_done_state", {62'd0, csAtDone, errAtDone}, 64'b10);
    checkOutput("wr_ready_tick", 64'(readyTick), 64'd26);

    // Register write: no latency, two bytes regardless of length.
    applyStimulus(48'h600000000000, 8'd9, 1'b0, -1, 30);
    checkOutput("reg_take_count", 64'(wrCount), 64'd2);
    checkOutput("reg_first_take", 64'(firstWr), 64'd6);
    checkOutput("reg_done_tick", 64'(doneTick), 64'd8);
    checkOutput("reg_ck_edges", 64'(ckEdges), 64'd8);

    // Read where RWDS never moves: timeout abort.
    applyStimulus(48'hA00000000010, 8'd3, 1'b0, -1, 100);
    checkOutput("to_cap_count", 64'(capCount), 64'd0);
    checkOutput("to_done_tick", 64'(doneTick), 64'd82);
    checkOutput("to_done_state", {62'd0, csAtDone, errAtDone}, 64'b11);
    checkOutput("to_ready_tick", 64'(readyTick), 64'd86);

    // Reset in the middle of a long write.
    startCmd(48'h200000000000, 8'd7);
    for (int t = 0; t < 20; t++) @(negedge Clk);
    #1;
    checkOutput("mid_wr_active", {62'd0, WrTake, CS}, 64'b10);
    Reset = 1'b1;
    #1;
    checkOutput("rst_mid_outputs", {59'd0, CS, CK, DoutEn, WrTake, CmdReady}, 64'b10000);
    @(negedge Clk);
    Reset = 1'b0;
    k = 0;
    #1;
    while (!CmdReady && k < 20) begin
      @(negedge Clk);
      #1;
      k++;
    end
    checkOutput("rst_ready_ticks", 64'(k), 64'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
